// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - opcode/funct constants, ALU encodings and control bundle for decode_stage
package decode_stage_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4
    } alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    reg_dst;
        alu_op_t alu_op;
    } ctrl_t;

    // beq is resolved in decode and has no EX work, so it maps to a bubble here.
    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                case (funct)
                    FN_ADD:  c.alu_op = ALU_ADD;
                    FN_SUB:  c.alu_op = ALU_SUB;
                    FN_AND:  c.alu_op = ALU_AND;
                    FN_OR:   c.alu_op = ALU_OR;
                    FN_SLT:  c.alu_op = ALU_SLT;
                    default: c = '0;
                endcase
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// rtl/decode_stage_register_file.sv - 2R1W register file, r0 hardwired to zero; DECODE_WB_BYPASS_EN forwards same-cycle writes
module register_file
    import decode_stage_pkg::*;
#(
    parameter int REG_COUNT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write_enable,
    input  logic [REG_IDX_W-1:0] write_reg,
    input  logic [31:0]          write_data,
    input  logic [REG_IDX_W-1:0] read_reg_1,
    input  logic [REG_IDX_W-1:0] read_reg_2,
    output logic [31:0]          read_data_1,
    output logic [31:0]          read_data_2
);

    logic [31:0] regs [REG_COUNT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable && (write_reg != '0)) begin
            regs[write_reg] <= write_data;
        end
    end

    always_comb begin
        read_data_1 = (read_reg_1 == '0) ? '0 : regs[read_reg_1];
`ifdef DECODE_WB_BYPASS_EN
        if (write_enable && (read_reg_1 != '0) && (read_reg_1 == write_reg)) begin
            read_data_1 = write_data;
        end
`endif
    end

    always_comb begin
        read_data_2 = (read_reg_2 == '0) ? '0 : regs[read_reg_2];
`ifdef DECODE_WB_BYPASS_EN
        if (write_enable && (read_reg_2 != '0) && (read_reg_2 == write_reg)) begin
            read_data_2 = write_data;
        end
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: decode, load-use stall, beq resolution, ID/EX register (optional DECODE_WB_BYPASS_EN)
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int REG_COUNT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          ifid_pc_next,
    input  logic [31:0]          ifid_instruction,
    input  logic                 wb_write_enable,
    input  logic [REG_IDX_W-1:0] wb_write_reg,
    input  logic [31:0]          wb_write_data,
    output logic                 pc_enable,
    output logic                 ifid_enable,
    output logic                 ifid_flush,
    output logic                 branch_taken,
    output logic [31:0]          branch_target,
    output logic [31:0]          idex_pc_next,
    output logic [31:0]          idex_read_data_1,
    output logic [31:0]          idex_read_data_2,
    output logic [31:0]          idex_immediate,
    output logic [REG_IDX_W-1:0] idex_rs,
    output logic [REG_IDX_W-1:0] idex_rt,
    output logic [REG_IDX_W-1:0] idex_rd,
    output logic                 idex_reg_write,
    output logic                 idex_mem_read,
    output logic                 idex_mem_write,
    output logic                 idex_mem_to_reg,
    output logic                 idex_alu_src,
    output logic                 idex_reg_dst,
    output logic [3:0]           idex_alu_op
);

    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic [REG_IDX_W-1:0] rs;
    logic [REG_IDX_W-1:0] rt;
    logic [REG_IDX_W-1:0] rd_sel;
    logic [31:0]          read_data_1;
    logic [31:0]          read_data_2;
    logic [31:0]          immediate;
    logic                 is_rtype;
    logic                 is_beq;
    logic                 uses_rt;
    logic                 stall;
    ctrl_t                ctrl;
    ctrl_t                idex_ctrl;

    assign opcode    = ifid_instruction[31:26];
    assign rs        = ifid_instruction[25:21];
    assign rt        = ifid_instruction[20:16];
    assign funct     = ifid_instruction[5:0];
    assign immediate = {{16{ifid_instruction[15]}}, ifid_instruction[15:0]};
    assign is_rtype  = (opcode == OP_RTYPE);
    assign is_beq    = (opcode == OP_BEQ);
    assign uses_rt   = is_rtype || is_beq || (opcode == OP_SW);
    assign rd_sel    = is_rtype ? ifid_instruction[15:11] : rt;

    register_file #(
        .REG_COUNT(REG_COUNT)
    ) u_register_file (
        .clk         (clk),
        .reset       (reset),
        .write_enable(wb_write_enable),
        .write_reg   (wb_write_reg),
        .write_data  (wb_write_data),
        .read_reg_1  (rs),
        .read_reg_2  (rt),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2)
    );

    // Reset gating keeps fetch running and the redirect quiet while the block is held in reset.
    assign stall = !reset && idex_mem_read && (idex_rt != '0) &&
                   ((idex_rt == rs) || (uses_rt && (idex_rt == rt)));

    assign pc_enable     = !stall;
    assign ifid_enable   = !stall;
    assign branch_taken  = !reset && is_beq && !stall && (read_data_1 == read_data_2);
    assign ifid_flush    = branch_taken;
    assign branch_target = ifid_pc_next + {immediate[29:0], 2'b00};

    always_comb begin
        ctrl = decode_ctrl(opcode, funct);
        if (stall) begin
            ctrl = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_ctrl        <= '0;
            idex_pc_next     <= '0;
            idex_read_data_1 <= '0;
            idex_read_data_2 <= '0;
            idex_immediate   <= '0;
            idex_rs          <= '0;
            idex_rt          <= '0;
            idex_rd          <= '0;
        end else begin
            idex_ctrl        <= ctrl;
            idex_pc_next     <= ifid_pc_next;
            idex_read_data_1 <= read_data_1;
            idex_read_data_2 <= read_data_2;
            idex_immediate   <= immediate;
            idex_rs          <= rs;
            idex_rt          <= rt;
            idex_rd          <= rd_sel;
        end
    end

    assign idex_reg_write  = idex_ctrl.reg_write;
    assign idex_mem_read   = idex_ctrl.mem_read;
    assign idex_mem_write  = idex_ctrl.mem_write;
    assign idex_mem_to_reg = idex_ctrl.mem_to_reg;
    assign idex_alu_src    = idex_ctrl.alu_src;
    assign idex_reg_dst    = idex_ctrl.reg_dst;
    assign idex_alu_op     = idex_ctrl.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage (honours DECODE_WB_BYPASS_EN)
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ifid_pc_next;
    logic [31:0] ifid_instruction;
    logic        wb_write_enable;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        pc_enable, ifid_enable, ifid_flush, branch_taken;
    logic [31:0] branch_target;
    logic [31:0] idex_pc_next, idex_read_data_1, idex_read_data_2, idex_immediate;
    logic [4:0]  idex_rs, idex_rt, idex_rd;
    logic        idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg, idex_alu_src, idex_reg_dst;
    logic [3:0]  idex_alu_op;
    logic [9:0]  idex_ctl;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ifid_pc_next    (ifid_pc_next),
        .ifid_instruction(ifid_instruction),
        .wb_write_enable (wb_write_enable),
        .wb_write_reg    (wb_write_reg),
        .wb_write_data   (wb_write_data),
        .pc_enable       (pc_enable),
        .ifid_enable     (ifid_enable),
        .ifid_flush      (ifid_flush),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .idex_pc_next    (idex_pc_next),
        .idex_read_data_1(idex_read_data_1),
        .idex_read_data_2(idex_read_data_2),
        .idex_immediate  (idex_immediate),
        .idex_rs         (idex_rs),
        .idex_rt         (idex_rt),
        .idex_rd         (idex_rd),
        .idex_reg_write  (idex_reg_write),
        .idex_mem_read   (idex_mem_read),
        .idex_mem_write  (idex_mem_write),
        .idex_mem_to_reg (idex_mem_to_reg),
        .idex_alu_src    (idex_alu_src),
        .idex_reg_dst    (idex_reg_dst),
        .idex_alu_op     (idex_alu_op)
    );

    assign idex_ctl = {idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg,
                       idex_alu_src, idex_reg_dst, idex_alu_op};

    typedef struct {
        logic        full;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [9:0]  ctl;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] pc_ctr = 32'h100;
    logic [5:0]  alu_fn [4] = '{6'h22, 6'h24, 6'h25, 6'h2A};

`ifdef DECODE_WB_BYPASS_EN
    localparam logic [31:0] R9_SAME_CYCLE = 32'h0000_1234;
`else
    localparam logic [31:0] R9_SAME_CYCLE = 32'h0000_0000;
`endif

    localparam logic [9:0] C_RADD = 10'b1_0_0_0_0_1_0000;
    localparam logic [9:0] C_LW   = 10'b1_1_0_1_1_0_0000;
    localparam logic [9:0] C_SW   = 10'b0_0_1_0_1_0_0000;
    localparam logic [9:0] C_ADDI = 10'b1_0_0_0_1_0_0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_op(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    task automatic drive(input logic [31:0] ins);
        ifid_instruction = ins;
        ifid_pc_next     = pc_ctr;
        pc_ctr           = pc_ctr + 32'd4;
    endtask

    task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
        wb_write_enable = en;
        wb_write_reg    = r;
        wb_write_data   = d;
    endtask

    task automatic expect_full(input logic [31:0] rd1, rd2, input logic [4:0] rd, input logic [9:0] c);
        exp_t e;
        e.full = 1'b1;
        e.pc   = ifid_pc_next;
        e.rd1  = rd1;
        e.rd2  = rd2;
        e.imm  = {{16{ifid_instruction[15]}}, ifid_instruction[15:0]};
        e.rs   = ifid_instruction[25:21];
        e.rt   = ifid_instruction[20:16];
        e.rd   = rd;
        e.ctl  = c;
        sb.push_back(e);
    endtask

    task automatic expect_bubble();
        exp_t e;
        e = '{full: 1'b0, pc: '0, rd1: '0, rd2: '0, imm: '0, rs: '0, rt: '0, rd: '0, ctl: '0};
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard: ID/EX update with no expected entry (t=%0t)", $time);
        end else begin
            e = sb.pop_front();
            check("idex_ctl", idex_ctl, e.ctl);
            if (e.full) begin
                check("idex_pc_next", idex_pc_next, e.pc);
                check("idex_read_data_1", idex_read_data_1, e.rd1);
                check("idex_read_data_2", idex_read_data_2, e.rd2);
                check("idex_immediate", idex_immediate, e.imm);
                check("idex_rs", idex_rs, e.rs);
                check("idex_rt", idex_rt, e.rt);
                check("idex_rd", idex_rd, e.rd);
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        wb(1'b0, 5'd0, 32'd0);
        drive(i_op(6'b000100, 5'd0, 5'd0, 16'hFFFE));
        #12;
        check("rst_pc_enable", pc_enable, 1);
        check("rst_ifid_enable", ifid_enable, 1);
        check("rst_branch_taken", branch_taken, 0);
        check("rst_ifid_flush", ifid_flush, 0);
        check("rst_idex_ctl", idex_ctl, 0);
        check("rst_idex_read_data_1", idex_read_data_1, 0);
        reset = 1'b0;

        drive(32'h0);
        wb(1'b1, 5'd5, 32'h0000_00FF); expect_bubble(); tick();
        wb(1'b1, 5'd1, 32'h0000_0010); expect_bubble(); tick();
        wb(1'b1, 5'd2, 32'h0000_0022); expect_bubble(); tick();
        wb(1'b1, 5'd6, 32'h0000_0007); expect_bubble(); tick();
        wb(1'b0, 5'd0, 32'd0);

        drive(r_op(5'd5, 5'd5, 5'd3, 6'h20));
        #1 check("add_pc_enable", pc_enable, 1);
        expect_full(32'hFF, 32'hFF, 5'd3, C_RADD); tick();

        for (int i = 0; i < 4; i++) begin
            drive(r_op(5'd5, 5'd6, 5'd3, alu_fn[i]));
            expect_full(32'hFF, 32'h7, 5'd3, {6'b100001, 4'(i + 1)}); tick();
        end

        drive(r_op(5'd5, 5'd6, 5'd3, 6'h21)); expect_bubble(); tick();
        drive(i_op(6'h3F, 5'd1, 5'd2, 16'h0004)); expect_bubble(); tick();

        drive(i_op(6'h23, 5'd1, 5'd2, 16'd4));
        expect_full(32'h10, 32'h22, 5'd2, C_LW); tick();
        drive(r_op(5'd2, 5'd6, 5'd4, 6'h20));
        #1 check("stall_pc_enable", pc_enable, 0);
        check("stall_ifid_enable", ifid_enable, 0);
        expect_bubble(); tick();
        #1 check("after_stall_pc_enable", pc_enable, 1);
        expect_full(32'h22, 32'h7, 5'd4, C_RADD); tick();

        drive(i_op(6'h23, 5'd1, 5'd2, 16'd4));
        expect_full(32'h10, 32'h22, 5'd2, C_LW); tick();
        drive(i_op(6'h08, 5'd1, 5'd2, 16'd1));
        #1 check("addi_rt_no_stall", pc_enable, 1);
        expect_full(32'h10, 32'h22, 5'd2, C_ADDI); tick();

        drive(i_op(6'h23, 5'd1, 5'd2, 16'd4));
        expect_full(32'h10, 32'h22, 5'd2, C_LW); tick();
        drive(i_op(6'h2B, 5'd1, 5'd2, 16'd0));
        #1 check("sw_rt_stall", pc_enable, 0);
        expect_bubble(); tick();
        expect_full(32'h10, 32'h22, 5'd2, C_SW); tick();

        drive(i_op(6'h23, 5'd1, 5'd0, 16'd0));
        expect_full(32'h10, 32'h0, 5'd0, C_LW); tick();
        drive(r_op(5'd0, 5'd6, 5'd4, 6'h20));
        #1 check("lw_r0_no_stall", pc_enable, 1);
        expect_full(32'h0, 32'h7, 5'd4, C_RADD); tick();

        pc_ctr = 32'h40;
        drive(i_op(6'h04, 5'd1, 5'd1, 16'hFFFE));
        #1 check("beq_taken", branch_taken, 1);
        check("beq_target", branch_target, 32'h38);
        check("beq_flush", ifid_flush, 1);
        expect_bubble(); tick();
        pc_ctr = 32'h40;
        drive(i_op(6'h04, 5'd1, 5'd2, 16'hFFFE));
        #1 check("beq_not_taken", branch_taken, 0);
        check("beq_not_taken_flush", ifid_flush, 0);
        expect_bubble(); tick();

        drive(i_op(6'h23, 5'd0, 5'd1, 16'd0));
        expect_full(32'h0, 32'h10, 5'd1, C_LW); tick();
        drive(i_op(6'h04, 5'd1, 5'd1, 16'hFFFE));
        #1 check("beq_stall_taken", branch_taken, 0);
        check("beq_stall_pc_enable", pc_enable, 0);
        expect_bubble(); tick();
        #1 check("beq_after_stall_taken", branch_taken, 1);
        expect_bubble(); tick();

        drive(32'h0);
        wb(1'b1, 5'd0, 32'hDEAD_BEEF); expect_bubble(); tick();
        wb(1'b0, 5'd0, 32'd0);
        drive(i_op(6'h08, 5'd0, 5'd7, 16'hFFFF));
        expect_full(32'h0, 32'h0, 5'd7, C_ADDI); tick();
        check("addi_sext_immediate", idex_immediate, 32'hFFFF_FFFF);

        wb(1'b1, 5'd9, 32'h0000_1234);
        drive(r_op(5'd9, 5'd0, 5'd10, 6'h20));
        expect_full(R9_SAME_CYCLE, 32'h0, 5'd10, C_RADD); tick();
        wb(1'b0, 5'd0, 32'd0);
        drive(r_op(5'd9, 5'd0, 5'd10, 6'h20));
        expect_full(32'h1234, 32'h0, 5'd10, C_RADD); tick();

        drive(i_op(6'h23, 5'd1, 5'd2, 16'd4));
        expect_full(32'h10, 32'h22, 5'd2, C_LW); tick();
        drive(r_op(5'd2, 5'd6, 5'd4, 6'h20));
        #1 check("pre_reset_stall", pc_enable, 0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_idex_ctl", idex_ctl, 0);
        check("async_rst_idex_read_data_1", idex_read_data_1, 0);
        check("async_rst_idex_immediate", idex_immediate, 0);
        check("async_rst_idex_pc_next", idex_pc_next, 0);
        check("async_rst_idex_rd", idex_rd, 0);
        check("async_rst_pc_enable", pc_enable, 1);
        check("async_rst_ifid_enable", ifid_enable, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check("post_reset_pc_enable", pc_enable, 1);
        expect_full(32'h0, 32'h0, 5'd4, C_RADD); tick();
        drive(r_op(5'd5, 5'd5, 5'd3, 6'h20));
        expect_full(32'h0, 32'h0, 5'd3, C_RADD); tick();

        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock and one reset: clk is the single clock and reset is asynchronous and active-high.
REQ-002 Parameter REG_COUNT, default 32, SHALL set the number of architectural registers, with index width 5.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 ifid_pc_next  in  32  PC+4 of the instruction in decode.
REQ-006 ifid_instruction  in  32  instruction in decode.
REQ-007 wb_write_enable, wb_write_reg, wb_write_data  in  1/5/32  register-file write port.
REQ-008 pc_enable, ifid_enable  out  1/1  fetch hold controls; 0 means hold.
REQ-009 ifid_flush  out  1  discard the fetched instruction.
REQ-010 branch_taken, branch_target  out  1/32  fetch redirect.
REQ-011 idex_pc_next, idex_read_data_1, idex_read_data_2, idex_immediate  out  32 each  ID/EX datapath.
REQ-012 idex_rs, idex_rt, idex_rd  out  5 each  ID/EX register indices.
REQ-013 idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg, idex_alu_src, idex_reg_dst  out  1 each  ID/EX control.
REQ-014 idex_alu_op  out  4  ALU operation: 0 add, 1 sub, 2 and, 3 or, 4 slt.

Function
REQ-015 Decode SHALL support these opcodes: R-type 000000 (funct add 100000, sub 100010, and 100100, or 100101, slt 101010), lw 100011, sw 101011, beq 000100, addi 001000.
REQ-016 An unknown opcode or funct SHALL decode as a bubble, with all ID/EX control bits 0.
REQ-017 The register file SHALL be REG_COUNT x 32 with 2 combinational read ports (rs = instr[25:21], rt = instr[20:16]) and 1 write port written on the rising edge when wb_write_enable=1.
REQ-018 Register 0 SHALL always read 0, and writes to register 0 SHALL be ignored.
REQ-019 The immediate SHALL be sign-extended from instr[15:0] to 32 bits.
REQ-020 branch_target SHALL equal ifid_pc_next + (immediate << 2), with 32-bit wrap-around and overflow ignored.
REQ-021 Load-use stall: when idex_mem_read=1, idex_rt!=0 and idex_rt equals the decode rs, or equals the decode rt for R-type/sw/beq, the block SHALL drive pc_enable=0 and ifid_enable=0 and load a bubble into ID/EX; otherwise both enables SHALL be 1.
REQ-022 A beq SHALL resolve in decode: branch_taken=1 when read_data_1==read_data_2, no stall is active, and the instruction is beq; ifid_flush SHALL equal branch_taken.
REQ-023 A beq SHALL load a bubble into ID/EX, because it has no EX work.
REQ-024 The ID/EX register SHALL update every rising edge; latency from ifid_instruction to the idex_* outputs SHALL be 1 cycle.
REQ-025 A stall together with a beq SHALL give priority to the stall, with branch_taken=0 in that cycle.
REQ-026 idex_rd SHALL be instr[15:11] for R-type and instr[20:16] otherwise; idex_reg_dst SHALL be 1 only for R-type.

Reset
REQ-027 Asserting reset SHALL immediately clear every idex_* output and every register-file entry to 0, independent of clk.
REQ-028 During reset, pc_enable and ifid_enable SHALL be 1 and branch_taken and ifid_flush SHALL be 0.
REQ-029 After reset is released mid-operation, the first rising edge SHALL capture the current decode normally, with no residual stall.

Configuration
REQ-030 Macro DECODE_WB_BYPASS_EN defined: a read of register r!=0 in the same cycle that wb_write_enable=1 writes r SHALL return wb_write_data.
REQ-031 Macro DECODE_WB_BYPASS_EN undefined: such a read SHALL return the old register value.

Structure
REQ-032 A shared package SHALL hold the opcode/funct constants, the alu_op encodings, and a control-bundle struct typedef.
REQ-033 The register file SHALL be one sub-module named register_file; decode and hazard logic SHALL live in decode_stage.

Verification
REQ-034 Write r5=0x0000_00FF via WB, then decode add r3,r5,r5 -> next cycle idex_read_data_1=idex_read_data_2=0xFF, idex_alu_op=0, idex_reg_write=1, idex_rd=3.
REQ-035 lw r2,4(r1) in ID/EX with add r4,r2,r6 in decode -> pc_enable=0, ifid_enable=0, next idex_reg_write=0; one cycle later the add issues.
REQ-036 beq r1,r1,-2 with ifid_pc_next=0x40 -> branch_taken=1, branch_target=0x38, ifid_flush=1; with r1!=r2, branch_taken=0.
REQ-037 Write r0=0xDEAD_BEEF, then read r0 -> 0; addi r7,r0,0xFFFF -> idex_immediate=0xFFFF_FFFF.
REQ-038 Same-cycle write r9=0x1234 and read r9 -> 0x1234 if DECODE_WB_BYPASS_EN is defined, otherwise the prior value.
REQ-039 Assert reset between clock edges while a stall is active -> all idex_* outputs are 0 immediately and pc_enable=1.
